seq_divider: RTL



---
 rtl/seq_div_pkg.sv | 13 +
 rtl/seq_divider_div_step.sv | 27 ++
 rtl/seq_divider.sv | 133 +++++++++++++
 3 files changed

// File: rtl/seq_div_pkg.sv
// Shared types and default widths for the sequential restoring divider.
package seq_div_pkg;

  localparam int unsigned N_WIDTH_DEF = 5;
  localparam int unsigned D_WIDTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/seq_divider_div_step.sv
// One combinational restoring-division iteration: shift in a dividend bit,
// trial-subtract the divisor, keep the difference when it does not underflow.
module div_step
  import seq_div_pkg::*;
#(
  parameter int unsigned D_WIDTH = D_WIDTH_DEF
) (
  input  logic [D_WIDTH:0]   r_i,
  input  logic               n_msb_i,
  input  logic [D_WIDTH-1:0] d_i,
  output logic [D_WIDTH:0]   r_o,
  output logic               q_o
);

  logic [D_WIDTH+1:0] t_wide;
  logic               geq;

  // r_i[D_WIDTH] is always zero between iterations; carrying it through the
  // compare leaves the result unchanged and keeps t free of truncation.
  always_comb begin
    t_wide = {r_i, n_msb_i};
    geq    = (t_wide >= {2'b00, d_i});
    q_o    = geq;
    r_o    = geq ? (t_wide[D_WIDTH:0] - {1'b0, d_i}) : t_wide[D_WIDTH:0];
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock, MSB
// first, with start/busy/done handshake and divide-by-zero flag.
module seq_divider
  import seq_div_pkg::*;
#(
  parameter int unsigned N_WIDTH = N_WIDTH_DEF,
  parameter int unsigned D_WIDTH = D_WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [N_WIDTH-1:0] dividend,
  input  logic [D_WIDTH-1:0] divisor,
  output logic               busy,
  output logic               done,
  output logic               dbz,
  output logic [N_WIDTH-1:0] quotient,
  output logic [D_WIDTH-1:0] remainder
);

  localparam int unsigned CNT_W = $clog2(N_WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_WIDTH - 1);

  state_e             state_q, state_d;
  logic [N_WIDTH-1:0] n_q, n_d;
  logic [D_WIDTH-1:0] d_q, d_d;
  logic [D_WIDTH:0]   r_q, r_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [N_WIDTH-1:0] quot_q, quot_d;
  logic [D_WIDTH-1:0] rem_q, rem_d;
  logic               dbz_q, dbz_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [D_WIDTH:0]   step_r;
  logic               step_q;

  div_step #(.D_WIDTH(D_WIDTH)) u_step (
    .r_i     (r_q),
    .n_msb_i (n_q[N_WIDTH-1]),
    .d_i     (d_q),
    .r_o     (step_r),
    .q_o     (step_q)
  );

  // Next-state logic: operand capture in IDLE/DONE, one iteration per RUN cycle.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    d_d     = d_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        if (start) begin
          n_d    = dividend;
          d_d    = divisor;
          r_d    = '0;
          cnt_d  = '0;
          dbz_d  = 1'b0;
          quot_d = '0;
          rem_d  = '0;
          if (divisor == '0) begin
            state_d = DONE;
            dbz_d   = 1'b1;
            quot_d  = '1;
            done_d  = 1'b1;
          end else begin
            state_d = RUN;
            busy_d  = 1'b1;
          end
        end
      end
      RUN: begin
        n_d   = {n_q[N_WIDTH-2:0], step_q};
        r_d   = step_r;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          quot_d  = {n_q[N_WIDTH-2:0], step_q};
          rem_d   = step_r[D_WIDTH-1:0];
          state_d = DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and result registers, cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      n_q     <= '0;
      d_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      d_q     <= d_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign dbz       = dbz_q;
  assign quotient  = quot_q;
  assign remainder = rem_q;

endmodule
